io_char_buffer: RTL and testbench
=================================

// Module: io_char_buffer
// PURPOSE
// - Parametrised successor to the G-15 OA/OB/OS I/O registers. Sits between the
//   input-device OR-bus / output format logic and the line-19/23 serial path.
// - Adds a DEPTH-entry character FIFO ahead of the OB character register, plus
//   an OA digit shifter and an OS sign flop.
// - Decodes OB format codes and gives a valid/ready handshake on both sides.
// PARAMETERS
// - CHAR_W  5  OB character width; bit CHAR_W-1 is the digit flag (OB5).
// - DIG_W   4  OA digit width; must be <= CHAR_W-1.
// - DEPTH   4  input FIFO entries; power of two, >= 2.
// PORTS
// - CLOCK      in   1       system clock, single domain
// - rst        in   1       synchronous, active-high reset
// - clr        in   1       READY-style clear: empties FIFO, clears OA/OB/OS
// - in_valid   in   1       input device character present
// - in_char    in   CHAR_W  input character (OR of device lines)
// - in_ready   out  1       FIFO not full
// - ob_load    in   1       pop FIFO head into OB
// - ob_valid   out  1       OB holds an unconsumed character
// - ob_char    out  CHAR_W  OB contents
// - ob_ack     in   1       consumer took OB; clears ob_valid
// - shift_en   in   1       OA serial shift (CIR_Y equivalent)
// - ser_in     in   1       serial bit into OA[0] (M19/M23 bit)
// - oa_to_ob   in   1       OB <= {1'b1, zero-ext OA} (digit assembly)
// - ob_to_oa   in   1       OA <= OB[DIG_W-1:0] when OB digit flag set
// - oa         out  DIG_W   OA contents
// - sign_set   in   1       OS <= 1 (minus)
// - sign_clr   in   1       OS <= 0
// - os         out  1       I/O word sign
// - fifo_cnt   out  $clog2(DEPTH)+1  occupancy
// - cr_tab_ob, sign_ob, tab_ob, wait_ob, stop_ob  out 1  combinational decodes of
//   OB[3:0] when OB digit flag = 0: 0x2/0x3 CR-TAB, 0x1 SIGN, 0x3 TAB, 0x7 WAIT,
//   0x4 STOP. Multiple may be active (TAB implies CR_TAB, as in the G-15 decode).
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty (fifo_cnt=0, in_ready=1), OA/OB/OS=0.
// - clr has the same effect as rst; rst dominates, clr dominates all other inputs.
// - FIFO push when in_valid & in_ready. Pop when ob_load & fifo_cnt!=0.
// - Pop of an empty FIFO: OB and ob_valid unchanged.
// - Push and pop in the same cycle when full: pop happens, push is refused
//   (in_ready=0 that cycle), count stays DEPTH-1.
// - Push/pop same cycle when neither full nor empty: count unchanged.
// - Pointers wrap modulo DEPTH.
// - Push-to-load latency: a character pushed in cycle N is poppable in N+1.
//   OB updates on the clock edge of the pop; ob_valid=1 the next cycle.
// - OB write priority, highest first: ob_load pop, oa_to_ob, none.
//   Any OB write sets ob_valid. ob_ack in the same cycle as a write is ignored
//   (new character stays valid).
// - OA priority: ob_to_oa (only when OB[CHAR_W-1]=1, else no-op) over shift_en.
//   Shift: OA <= {OA[DIG_W-2:0], ser_in}.
// - oa_to_ob and ob_to_oa in the same cycle: both occur using pre-edge values
//   (swap semantics).
// - OS: sign_clr dominates sign_set. In addition, OS is set on an OB load whose
//   new value decodes as SIGN.
// - All decodes are registered-input/combinational-output, no added latency.
// STRUCTURE
// - Package io_pkg:
//   - typedef ob_code_e (CR=0x2, SIGN=0x1, TAB=0x3, WAIT=0x7, STOP=0x4)
//   - localparam DIGIT_FLAG_BIT function of CHAR_W
// - One sub-module io_char_fifo (DEPTH x CHAR_W, registers, cnt/ptrs).
// - OA, OB and OS stay in the top level.
// TESTING
// - Reset, then push 0x11,0x03,0x07,0x04 -> fifo_cnt=4, in_ready=0.
//   A fifth push is dropped.
// - Pop 4x -> OB 0x11 then 0x03 (tab_ob=cr_tab_ob=1), 0x07 (wait_ob), 0x04 (stop_ob).
//   A 5th pop with cnt=0 leaves OB=0x04.
// - Full FIFO, push+pop same cycle -> cnt 4->3, pushed value absent.
//   Wrap test: 10 push/pop pairs preserve order.
// - shift_en 4 cycles with ser_in 1,0,1,1 -> oa=4'b1011.
//   oa_to_ob -> ob_char=0x1B, ob_valid=1.
// - OB=0x16, ob_to_oa -> oa=0x6. OB=0x06, ob_to_oa -> oa unchanged.
// - sign_set+sign_clr same cycle -> os=0. Load SIGN code 0x01 -> os=1.
//   clr mid-fill (cnt=2) -> cnt=0, ob_char=0, os=0 next cycle.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared codes, defaults and helpers for the G-15 style I/O character buffer
package io_pkg;

  // Non-digit OB format codes, found in OB[3:0] when the digit flag is clear.
  typedef enum logic [3:0] {
    OB_SIGN = 4'h1,
    OB_CR   = 4'h2,
    OB_TAB  = 4'h3,
    OB_STOP = 4'h4,
    OB_WAIT = 4'h7
  } ob_code_e;

  localparam int CHAR_W_DEF = 5;
  localparam int DIG_W_DEF  = 4;
  localparam int DEPTH_DEF  = 4;

  // The digit flag (OB5 on the original machine) is always the top character bit.
  function automatic int digit_flag_bit(input int char_w);
    return char_w - 1;
  endfunction

  localparam int DIGIT_FLAG_BIT = digit_flag_bit(CHAR_W_DEF);

endpackage

// File: rtl/io_char_fifo.sv
// rtl/io_char_fifo.sv - DEPTH x W register FIFO feeding the OB character register
module io_char_fifo
  import io_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int W     = CHAR_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  // A push into a full FIFO is refused even if a pop frees a slot that cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by reset or the READY-style clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Character storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !(rst || clr)) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_char_buffer.sv
// rtl/io_char_buffer.sv - OA/OB/OS I/O registers with an input character FIFO ahead of OB
module io_char_buffer
  import io_pkg::*;
#(
  parameter  int CHAR_W = CHAR_W_DEF,
  parameter  int DIG_W  = DIG_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_char,
  output logic              in_ready,
  input  logic              ob_load,
  output logic              ob_valid,
  output logic [CHAR_W-1:0] ob_char,
  input  logic              ob_ack,
  input  logic              shift_en,
  input  logic              ser_in,
  input  logic              oa_to_ob,
  input  logic              ob_to_oa,
  output logic [DIG_W-1:0]  oa,
  input  logic              sign_set,
  input  logic              sign_clr,
  output logic              os,
  output logic [CNT_W-1:0]  fifo_cnt,
  output logic              cr_tab_ob,
  output logic              sign_ob,
  output logic              tab_ob,
  output logic              wait_ob,
  output logic              stop_ob
);

  localparam int FLAG = digit_flag_bit(CHAR_W);

  logic [CHAR_W-1:0] ob_q, ob_d;
  logic              ob_valid_q, ob_valid_d;
  logic [DIG_W-1:0]  oa_q, oa_d;
  logic              os_q, os_d;
  logic              ob_we;
  logic              pop_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CHAR_W-1:0] fifo_head;

  // True when a character is a non-digit carrying the given format code.
  function automatic logic code_is(input logic [CHAR_W-1:0] v, input ob_code_e c);
    return !v[FLAG] && (v[3:0] == c);
  endfunction

  io_char_fifo #(
    .DEPTH (DEPTH),
    .W     (CHAR_W)
  ) u_fifo (
    .clk   (CLOCK),
    .rst   (rst),
    .clr   (clr),
    .push  (in_valid),
    .wdata (in_char),
    .pop   (ob_load),
    .rdata (fifo_head),
    .cnt   (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = ~fifo_full;
  assign pop_ok   = ob_load & ~fifo_empty;

  // OB/OA/OS next state; every source reads pre-edge values so OA<->OB transfers swap.
  always_comb begin
    ob_d       = ob_q;
    ob_we      = 1'b0;
    ob_valid_d = ob_valid_q;
    oa_d       = oa_q;
    os_d       = os_q;

    if (pop_ok) begin
      ob_d  = fifo_head;
      ob_we = 1'b1;
    end else if (oa_to_ob) begin
      ob_d              = '0;
      ob_d[DIG_W-1:0]   = oa_q;
      ob_d[FLAG]        = 1'b1;
      ob_we             = 1'b1;
    end

    // A fresh character wins over an acknowledge of the old one.
    if (ob_we)       ob_valid_d = 1'b1;
    else if (ob_ack) ob_valid_d = 1'b0;

    if (ob_to_oa && ob_q[FLAG]) oa_d = ob_q[DIG_W-1:0];
    else if (shift_en)          oa_d = {oa_q[DIG_W-2:0], ser_in};

    if (sign_clr)                                      os_d = 1'b0;
    else if (sign_set || (ob_we && code_is(ob_d, OB_SIGN))) os_d = 1'b1;
  end

  // OA/OB/OS registers; reset dominates clear, clear dominates all other inputs.
  always_ff @(posedge CLOCK) begin
    if (rst || clr) begin
      ob_q       <= '0;
      ob_valid_q <= 1'b0;
      oa_q       <= '0;
      os_q       <= 1'b0;
    end else begin
      ob_q       <= ob_d;
      ob_valid_q <= ob_valid_d;
      oa_q       <= oa_d;
      os_q       <= os_d;
    end
  end

  assign ob_char   = ob_q;
  assign ob_valid  = ob_valid_q;
  assign oa        = oa_q;
  assign os        = os_q;

  // TAB also raises CR_TAB, matching the original G-15 decode.
  assign cr_tab_ob = code_is(ob_q, OB_CR) | code_is(ob_q, OB_TAB);
  assign sign_ob   = code_is(ob_q, OB_SIGN);
  assign tab_ob    = code_is(ob_q, OB_TAB);
  assign wait_ob   = code_is(ob_q, OB_WAIT);
  assign stop_ob   = code_is(ob_q, OB_STOP);

endmodule

// File: tb/tb_io_char_buffer.sv
// tb/tb_io_char_buffer.sv - scoreboard bench for io_char_buffer against a queue-based reference model
module tb_io_char_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, ob_load, ob_ack, shift_en, ser_in;
  logic       oa_to_ob, ob_to_oa, sign_set, sign_clr;
  logic [4:0] in_char;
  logic       in_ready, ob_valid, os;
  logic [4:0] ob_char;
  logic [3:0] oa;
  logic [2:0] fifo_cnt;
  logic       cr_tab_ob, sign_ob, tab_ob, wait_ob, stop_ob;

  io_char_buffer #(.CHAR_W(5), .DIG_W(4), .DEPTH(DEPTH)) dut (
    .CLOCK     (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .ob_load   (ob_load),
    .ob_valid  (ob_valid),
    .ob_char   (ob_char),
    .ob_ack    (ob_ack),
    .shift_en  (shift_en),
    .ser_in    (ser_in),
    .oa_to_ob  (oa_to_ob),
    .ob_to_oa  (ob_to_oa),
    .oa        (oa),
    .sign_set  (sign_set),
    .sign_clr  (sign_clr),
    .os        (os),
    .fifo_cnt  (fifo_cnt),
    .cr_tab_ob (cr_tab_ob),
    .sign_ob   (sign_ob),
    .tab_ob    (tab_ob),
    .wait_ob   (wait_ob),
    .stop_ob   (stop_ob)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int in_ready;
    int ob_valid;
    int ob;
    int oa;
    int os;
    int crt;
    int sg;
    int tb;
    int wt;
    int st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: the FIFO is just a queue of characters.
  int mq[$];
  int m_ob  = 0;
  int m_obv = 0;
  int m_oa  = 0;
  int m_os  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rst = 0; clr = 0; in_valid = 0; in_char = 0; ob_load = 0; ob_ack = 0;
    shift_en = 0; ser_in = 0; oa_to_ob = 0; ob_to_oa = 0; sign_set = 0; sign_clr = 0;
  endtask

  // Apply current inputs for one cycle: update the model, queue the expectation, clock.
  task automatic tick();
    exp_t e;
    int   old_ob, old_oa, low;
    bit   pop_ok, push_ok, wr;
    if (rst || clr) begin
      mq.delete();
      m_ob = 0; m_obv = 0; m_oa = 0; m_os = 0;
    end else begin
      old_ob  = m_ob;
      old_oa  = m_oa;
      pop_ok  = ob_load && (mq.size() > 0);
      push_ok = in_valid && (mq.size() < DEPTH);
      wr      = 0;
      if (pop_ok) begin
        m_ob = mq.pop_front();
        wr   = 1;
      end else if (oa_to_ob) begin
        m_ob = 16 + old_oa;
        wr   = 1;
      end
      if (push_ok) mq.push_back(int'(in_char));
      if (wr) m_obv = 1;
      else if (ob_ack) m_obv = 0;
      if (ob_to_oa && old_ob >= 16) m_oa = old_ob % 16;
      else if (shift_en) m_oa = (old_oa * 2 + int'(ser_in)) % 16;
      if (sign_clr) m_os = 0;
      else if (sign_set || (wr && m_ob == 1)) m_os = 1;
    end
    low        = m_ob % 16;
    e.cnt      = mq.size();
    e.in_ready = (mq.size() != DEPTH);
    e.ob_valid = m_obv;
    e.ob       = m_ob;
    e.oa       = m_oa;
    e.os       = m_os;
    e.crt      = (m_ob < 16) && (low == 2 || low == 3);
    e.sg       = (m_ob < 16) && (low == 1);
    e.tb       = (m_ob < 16) && (low == 3);
    e.wt       = (m_ob < 16) && (low == 7);
    e.st       = (m_ob < 16) && (low == 4);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic push_char(input int v);
    in_valid = 1; in_char = 5'(v); tick();
  endtask

  task automatic pop_char();
    ob_load = 1; tick();
  endtask

  // Monitor: compare every registered output against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("fifo_cnt",  int'(fifo_cnt),  mon_e.cnt);
      chk("in_ready",  int'(in_ready),  mon_e.in_ready);
      chk("ob_valid",  int'(ob_valid),  mon_e.ob_valid);
      chk("ob_char",   int'(ob_char),   mon_e.ob);
      chk("oa",        int'(oa),        mon_e.oa);
      chk("os",        int'(os),        mon_e.os);
      chk("cr_tab_ob", int'(cr_tab_ob), mon_e.crt);
      chk("sign_ob",   int'(sign_ob),   mon_e.sg);
      chk("tab_ob",    int'(tab_ob),    mon_e.tb);
      chk("wait_ob",   int'(wait_ob),   mon_e.wt);
      chk("stop_ob",   int'(stop_ob),   mon_e.st);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seq[4];
    int wv[10];
    int bits[4];
    clear_inputs();

    rst = 1; tick();
    chk("reset_cnt",   int'(fifo_cnt), 0);
    chk("reset_ready", int'(in_ready), 1);
    chk("reset_ob",    int'(ob_char),  0);
    chk("reset_obv",   int'(ob_valid), 0);

    seq = '{5'h11, 5'h03, 5'h07, 5'h04};
    foreach (seq[i]) push_char(seq[i]);
    chk("full_cnt",   int'(fifo_cnt), 4);
    chk("full_ready", int'(in_ready), 0);
    push_char(5'h1F);
    chk("drop_cnt", int'(fifo_cnt), 4);

    pop_char(); chk("pop1_ob", int'(ob_char), 5'h11); chk("pop1_obv", int'(ob_valid), 1);
    pop_char(); chk("pop2_ob", int'(ob_char), 5'h03); chk("pop2_tab", int'(tab_ob), 1);
    chk("pop2_crtab", int'(cr_tab_ob), 1);
    pop_char(); chk("pop3_wait", int'(wait_ob), 1);
    pop_char(); chk("pop4_stop", int'(stop_ob), 1);
    pop_char(); chk("pop5_ob", int'(ob_char), 5'h04); chk("pop5_cnt", int'(fifo_cnt), 0);

    seq = '{5'h05, 5'h06, 5'h08, 5'h09};
    foreach (seq[i]) push_char(seq[i]);
    in_valid = 1; in_char = 5'h0A; ob_load = 1; tick();
    chk("fullpp_cnt", int'(fifo_cnt), 3);
    chk("fullpp_ob",  int'(ob_char),  5'h05);
    repeat (4) pop_char();
    chk("fullpp_last", int'(ob_char), 5'h09);
    chk("fullpp_empty", int'(fifo_cnt), 0);

    ob_ack = 1; tick();
    chk("ack_clears", int'(ob_valid), 0);
    push_char(5'h0C);
    ob_load = 1; ob_ack = 1; tick();
    chk("ack_ignored", int'(ob_valid), 1);

    for (int i = 0; i < 10; i++) begin
      wv[i] = (i * 7 + 3) % 32;
      in_valid = 1; in_char = 5'(wv[i]); ob_load = 1; tick();
      if (i > 0) chk("wrap_order", int'(ob_char), wv[i-1]);
    end
    pop_char();
    chk("wrap_last", int'(ob_char), wv[9]);

    bits = '{1, 0, 1, 1};
    foreach (bits[i]) begin
      shift_en = 1; ser_in = bits[i][0]; tick();
    end
    chk("shift_oa", int'(oa), 4'hB);
    oa_to_ob = 1; tick();
    chk("oa_to_ob", int'(ob_char), 5'h1B);
    chk("oa_to_ob_v", int'(ob_valid), 1);

    push_char(5'h16); pop_char();
    ob_to_oa = 1; tick();
    chk("ob_to_oa", int'(oa), 4'h6);
    shift_en = 1; ser_in = 1; tick();
    push_char(5'h06); pop_char();
    ob_to_oa = 1; tick();
    chk("ob_to_oa_noflag", int'(oa), 4'hD);

    oa_to_ob = 1; tick();
    shift_en = 1; ser_in = 0; tick();
    oa_to_ob = 1; ob_to_oa = 1; tick();
    chk("swap_ob", int'(ob_char), 5'h1A);
    chk("swap_oa", int'(oa), 4'hD);

    sign_set = 1; tick();
    chk("sign_set", int'(os), 1);
    sign_set = 1; sign_clr = 1; tick();
    chk("sign_clr_dom", int'(os), 0);
    push_char(5'h01); pop_char();
    chk("sign_load_os", int'(os), 1);
    chk("sign_load_dec", int'(sign_ob), 1);

    push_char(5'h02); push_char(5'h03);
    chk("clr_pre_cnt", int'(fifo_cnt), 2);
    clr = 1; tick();
    chk("clr_cnt", int'(fifo_cnt), 0);
    chk("clr_ob",  int'(ob_char),  0);
    chk("clr_os",  int'(os),       0);
    chk("clr_ready", int'(in_ready), 1);

    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(299) == 0);
      clr      = ($urandom_range(149) == 0);
      in_valid = ($urandom_range(1) == 1);
      in_char  = 5'($urandom_range(31));
      if ($urandom_range(3) == 0) in_char = 5'($urandom_range(7));
      ob_load  = ($urandom_range(9) < 4);
      ob_ack   = ($urandom_range(9) < 3);
      shift_en = ($urandom_range(9) < 3);
      ser_in   = 1'($urandom_range(1));
      oa_to_ob = ($urandom_range(9) == 0);
      ob_to_oa = ($urandom_range(9) == 0);
      sign_set = ($urandom_range(9) == 0);
      sign_clr = ($urandom_range(9) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
